// File: rtl/krnl_rtl_stream_pattern_generator_if.sv
// AXI4-Stream bundle for the pattern generator output.
// Master drives tvalid/tdata/tkeep/tlast; the slave drives tready.
interface krnl_rtl_stream_pattern_generator_if #(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 128
) ();
  logic                              tvalid;
  logic                              tready;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   tdata;
  logic [C_M_AXIS_TDATA_WIDTH/8-1:0] tkeep;
  logic                              tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/krnl_rtl_stream_pattern_generator.sv
// Runtime-configurable AXI4-Stream pattern source (increment/constant/decrement).
// Optional accepted-beat counter output stat_beats under `define PATTERN_GEN_BEAT_COUNT_EN.
module krnl_rtl_stream_pattern_generator #(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 128,
  parameter int unsigned C_NUMBER_BIT_WIDTH   = 32,
  parameter int unsigned C_LENGTH_WIDTH       = 32
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          ap_start,
  output logic                          ap_idle,
  output logic                          ap_done,
  input  logic [C_LENGTH_WIDTH-1:0]     cfg_length_bytes,
  input  logic [C_NUMBER_BIT_WIDTH-1:0] cfg_start_value,
  input  logic [C_NUMBER_BIT_WIDTH-1:0] cfg_stride,
  input  logic [1:0]                    cfg_mode,
`ifdef PATTERN_GEN_BEAT_COUNT_EN
  output logic [C_LENGTH_WIDTH-1:0]     stat_beats,
`endif
  krnl_rtl_stream_pattern_generator_if.master m_axis
);
  localparam int unsigned DW = C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned NW = C_NUMBER_BIT_WIDTH;
  localparam int unsigned LW = C_LENGTH_WIDTH;
  localparam int unsigned L  = DW / NW;
  localparam int unsigned B  = DW / 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_CONST = 2'd1,
    MODE_DEC   = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  state_t        r_state, w_state_nxt;
  logic [LW-1:0] r_beat, r_last_beat;
  logic [B-1:0]  r_last_keep;
  logic [DW-1:0] r_data;
  logic [NW-1:0] r_step;

  mode_t         w_mode;
  logic          w_capture, w_accept, w_is_last;
  logic [LW-1:0] w_rem, w_beats;
  logic [B-1:0]  w_keep_mask;
  logic [DW-1:0] w_init, w_stepped;
  logic [NW-1:0] w_step;

  assign w_mode    = mode_t'(cfg_mode);
  assign w_capture = (r_state == S_IDLE) && ap_start;
  assign w_accept  = (r_state == S_RUN) && m_axis.tready;
  assign w_is_last = (r_beat == r_last_beat);
  assign w_rem     = cfg_length_bytes % LW'(B);
  assign w_beats   = (cfg_length_bytes / LW'(B)) + LW'(w_rem != '0);

  // Lanes hold start +/- i*stride from capture on; each accepted beat adds one
  // precomputed +/-L*stride step, so the per-beat path is adders only.
  always_comb begin
    w_init      = '0;
    w_stepped   = '0;
    w_keep_mask = '0;
    case (w_mode)
      MODE_CONST: w_step = '0;
      MODE_DEC:   w_step = -(NW'(L) * cfg_stride);
      default:    w_step = NW'(L) * cfg_stride;
    endcase
    for (int unsigned i = 0; i < L; i++) begin
      case (w_mode)
        MODE_CONST: w_init[i*NW +: NW] = cfg_start_value;
        MODE_DEC:   w_init[i*NW +: NW] = cfg_start_value - NW'(i) * cfg_stride;
        default:    w_init[i*NW +: NW] = cfg_start_value + NW'(i) * cfg_stride;
      endcase
      w_stepped[i*NW +: NW] = r_data[i*NW +: NW] + r_step;
    end
    for (int unsigned j = 0; j < B; j++) begin
      w_keep_mask[j] = (w_rem == '0) || (LW'(j) < w_rem);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (ap_start) w_state_nxt = (cfg_length_bytes != '0) ? S_RUN : S_DONE;
      S_RUN:  if (w_accept && w_is_last) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_data      <= '0;
      r_step      <= '0;
      r_beat      <= '0;
      r_last_beat <= '0;
      r_last_keep <= '1;
    end else if (w_capture) begin
      r_data      <= w_init;
      r_step      <= w_step;
      r_beat      <= '0;
      r_last_beat <= w_beats - LW'(1);
      r_last_keep <= w_keep_mask;
    end else if (w_accept) begin
      r_data <= w_stepped;
      r_beat <= r_beat + LW'(1);
    end
  end

  assign m_axis.tvalid = (r_state == S_RUN);
  assign m_axis.tlast  = (r_state == S_RUN) && w_is_last;
  assign m_axis.tkeep  = m_axis.tlast ? r_last_keep : '1;
  assign m_axis.tdata  = r_data;
  assign ap_idle       = (r_state == S_IDLE);
  assign ap_done       = (r_state == S_DONE);

`ifdef PATTERN_GEN_BEAT_COUNT_EN
  logic [LW-1:0] r_stat;
  always_ff @(posedge aclk) begin
    if (areset || w_capture)           r_stat <= '0;
    else if (w_accept && r_stat != '1) r_stat <= r_stat + LW'(1);
  end
  assign stat_beats = r_stat;
`endif
endmodule

// File: tb/tb_krnl_rtl_stream_pattern_generator.sv
// Randomized bench for krnl_rtl_stream_pattern_generator against a beat-queue reference model.
module tb_krnl_rtl_stream_pattern_generator;
  localparam int unsigned DW = 128;
  localparam int unsigned NW = 32;
  localparam int unsigned LW = 32;
  localparam int unsigned L  = DW / NW;
  localparam int unsigned B  = DW / 8;

  logic          aclk = 1'b0;
  logic          areset, ap_start, ap_idle, ap_done;
  logic [LW-1:0] cfg_length_bytes;
  logic [NW-1:0] cfg_start_value, cfg_stride;
  logic [1:0]    cfg_mode;
`ifdef PATTERN_GEN_BEAT_COUNT_EN
  logic [LW-1:0] stat_beats;
`endif

  krnl_rtl_stream_pattern_generator_if #(.C_M_AXIS_TDATA_WIDTH(DW)) axis ();

  krnl_rtl_stream_pattern_generator #(
    .C_M_AXIS_TDATA_WIDTH(DW),
    .C_NUMBER_BIT_WIDTH(NW),
    .C_LENGTH_WIDTH(LW)
  ) u_dut (
    .aclk(aclk),
    .areset(areset),
    .ap_start(ap_start),
    .ap_idle(ap_idle),
    .ap_done(ap_done),
    .cfg_length_bytes(cfg_length_bytes),
    .cfg_start_value(cfg_start_value),
    .cfg_stride(cfg_stride),
    .cfg_mode(cfg_mode),
`ifdef PATTERN_GEN_BEAT_COUNT_EN
    .stat_beats(stat_beats),
`endif
    .m_axis(axis.master)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] data;
    logic [B-1:0]  keep;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  beat_t acc_log[$];
  bit    m_done_now = 1'b0;
  int    m_stat = 0;
  int    m_captures = 0;
  int    n_done_seen = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  bit    chk_en = 1'b0;
  int    rdy_mode = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Whole run expanded from the pattern rules: value of lane i on beat b uses k = b*L+i.
  function automatic void build_run(input logic [LW-1:0] len, input logic [NW-1:0] st,
                                    input logic [NW-1:0] stride, input logic [1:0] mode);
    int    nb = (int'(len) + int'(B) - 1) / int'(B);
    int    r  = int'(len) % int'(B);
    beat_t bt;
    logic [NW-1:0] kk, v;
    for (int b = 0; b < nb; b++) begin
      bt.data = '0;
      for (int i = 0; i < int'(L); i++) begin
        kk = NW'(b * int'(L) + i);
        if (mode == 2'd1)      v = st;
        else if (mode == 2'd2) v = st - kk * stride;
        else                   v = st + kk * stride;
        bt.data[i*NW +: NW] = v;
      end
      for (int j = 0; j < int'(B); j++) bt.keep[j] = (b != nb - 1) || (r == 0) || (j < r);
      bt.last = (b == nb - 1);
      exp_q.push_back(bt);
    end
  endfunction

  // Per-cycle compare, then advance the model to what the coming edge implies.
  always @(negedge aclk) begin
    bit    ev;
    beat_t got;
    if (chk_en) begin
      ev = exp_q.size() > 0;
      if (ap_done) n_done_seen++;
      check("tvalid", DW'(axis.tvalid), DW'(ev));
      check("ap_done", DW'(ap_done), DW'(m_done_now));
      check("ap_idle", DW'(ap_idle), DW'(!ev && !m_done_now));
`ifdef PATTERN_GEN_BEAT_COUNT_EN
      check("stat_beats", DW'(stat_beats), DW'(m_stat));
`endif
      if (ev && axis.tvalid) begin
        check("tdata", axis.tdata, exp_q[0].data);
        check("tkeep", DW'(axis.tkeep), DW'(exp_q[0].keep));
        check("tlast", DW'(axis.tlast), DW'(exp_q[0].last));
      end
      if (areset) begin
        exp_q.delete();
        m_done_now = 1'b0;
        m_stat = 0;
      end else if (m_done_now) begin
        m_done_now = 1'b0;
      end else if (ev) begin
        if (axis.tready) begin
          got.data = axis.tdata;
          got.keep = axis.tkeep;
          got.last = axis.tlast;
          acc_log.push_back(got);
          if (exp_q[0].last) m_done_now = 1'b1;
          exp_q.pop_front();
          m_stat++;
        end
      end else if (ap_start) begin
        m_captures++;
        m_stat = 0;
        build_run(cfg_length_bytes, cfg_start_value, cfg_stride, cfg_mode);
        if (exp_q.size() == 0) m_done_now = 1'b1;
      end
    end
  end

  initial begin
    int ph = 0;
    axis.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0: axis.tready = 1'b1;
        1: axis.tready = 1'($urandom_range(0, 1));
        default: begin
          axis.tready = (ph == 0);
          ph = (ph + 1) % 3;
        end
      endcase
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() > 0 || m_done_now) && n < 3000) begin
      @(posedge aclk);
      n++;
    end
    if (n >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_timeout: still busy after %0d cycles, required idle", n);
    end
    @(posedge aclk);
  endtask

  task automatic launch(input logic [LW-1:0] len, input logic [NW-1:0] st,
                        input logic [NW-1:0] stride, input logic [1:0] mode);
    @(posedge aclk);
    #1;
    cfg_length_bytes = len;
    cfg_start_value  = st;
    cfg_stride       = stride;
    cfg_mode         = mode;
    ap_start         = 1'b1;
    @(posedge aclk);
    #1;
    ap_start         = 1'b0;
    cfg_length_bytes = $urandom_range(1, 200);
    cfg_start_value  = $urandom;
    cfg_stride       = $urandom;
    cfg_mode         = 2'($urandom_range(0, 3));
  endtask

  task automatic run(input logic [LW-1:0] len, input logic [NW-1:0] st,
                     input logic [NW-1:0] stride, input logic [1:0] mode);
    acc_log.delete();
    launch(len, st, stride, mode);
    wait_idle();
  endtask

  initial begin
    int d0, n;
    areset = 1'b1;
    ap_start = 1'b0;
    cfg_length_bytes = '0;
    cfg_start_value = '0;
    cfg_stride = '0;
    cfg_mode = '0;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    chk_en = 1'b1;
    @(negedge aclk);
    check("rst_tvalid", DW'(axis.tvalid), '0);
    check("rst_tlast", DW'(axis.tlast), '0);
    check("rst_ap_idle", DW'(ap_idle), DW'(1));
    check("rst_tdata", axis.tdata, '0);
    check("rst_tkeep", DW'(axis.tkeep), DW'(16'hFFFF));

    rdy_mode = 0;
    d0 = n_done_seen;
    run(64, 32'h0, 32'h1, 2'd0);
    check("t1_beats", DW'(acc_log.size()), DW'(4));
    check("t1_b3_lane15", DW'(acc_log[3].data[127:96]), DW'(32'h0000000F));
    check("t1_b3_last", DW'(acc_log[3].last), DW'(1));
    check("t1_done", DW'(n_done_seen - d0), DW'(1));

    run(20, 32'h100, 32'h4, 2'd0);
    check("t2_beats", DW'(acc_log.size()), DW'(2));
    check("t2_b1_lane0", DW'(acc_log[1].data[31:0]), DW'(32'h110));
    check("t2_b1_keep", DW'(acc_log[1].keep), DW'(16'h000F));

    rdy_mode = 2;
    run(48, 32'h55, 32'h3, 2'd0);
    check("t3_beats", DW'(acc_log.size()), DW'(3));
    rdy_mode = 0;

    run(16, 32'h1, 32'h1, 2'd2);
    check("t4_data", acc_log[0].data, {32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});

    run(32, 32'hA5A5A5A5, 32'h7, 2'd1);
    check("t5_beats", DW'(acc_log.size()), DW'(2));
    check("t5_b1", acc_log[1].data, {4{32'hA5A5A5A5}});

    d0 = n_done_seen;
    run(0, 32'h9, 32'h9, 2'd0);
    check("t6_beats", DW'(acc_log.size()), '0);
    check("t6_done", DW'(n_done_seen - d0), DW'(1));

    // held ap_start relaunches from IDLE
    acc_log.delete();
    d0 = n_done_seen;
    n = m_captures;
    @(posedge aclk);
    #1;
    cfg_length_bytes = 32;
    cfg_start_value = 32'h10;
    cfg_stride = 32'h2;
    cfg_mode = 2'd0;
    ap_start = 1'b1;
    for (int c = 0; c < 200 && m_captures < n + 2; c++) @(posedge aclk);
    #1;
    ap_start = 1'b0;
    wait_idle();
    check("held_done", DW'(n_done_seen - d0), DW'(2));
    check("held_beats", DW'(acc_log.size()), DW'(4));

    // reset after the first accepted beat
    acc_log.delete();
    d0 = n_done_seen;
    launch(64, 32'h7, 32'h3, 2'd0);
    for (int c = 0; c < 200 && acc_log.size() < 1; c++) @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("rmid_tvalid", DW'(axis.tvalid), '0);
    check("rmid_idle", DW'(ap_idle), DW'(1));
    repeat (3) @(posedge aclk);
    check("rmid_no_done", DW'(n_done_seen - d0), '0);
    run(64, 32'h7, 32'h3, 2'd0);
    check("rmid_restart", DW'(acc_log[0].data[31:0]), DW'(32'h7));

    for (int t = 0; t < 40; t++) begin
      rdy_mode = $urandom_range(0, 2);
      run($urandom_range(0, 150), $urandom, $urandom, 2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end
endmodule
